// File: rtl/rank_pkg.sv
// Shared request/response word formats for the rank requester and rank_responder.
// Both ends import this package so the field layout is defined in one place.
package rank_pkg;

    localparam int ID_W   = 2;
    localparam int NODE_W = 7;
    localparam int RANK_W = 16;
    localparam int REQ_W  = 12;
    localparam int RESP_W = ID_W + NODE_W + RANK_W;

    localparam int REQ_SRC_HI   = 11;
    localparam int REQ_SRC_LO   = 10;
    localparam int REQ_DST_HI   = 9;
    localparam int REQ_DST_LO   = 8;
    localparam int REQ_RSVD_BIT = 7;
    localparam int REQ_NODE_HI  = 6;
    localparam int REQ_NODE_LO  = 0;

    typedef struct packed {
        logic [ID_W-1:0]   src_id;
        logic [ID_W-1:0]   dst_id;
        logic              rsvd;
        logic [NODE_W-1:0] node;
    } req_t;

    typedef struct packed {
        logic [ID_W-1:0]   src_id;
        logic [NODE_W-1:0] node;
        logic [RANK_W-1:0] rank;
    } resp_t;

    typedef enum logic [1:0] {IDLE, FETCH, LOOKUP, SEND} state_t;

    function automatic req_t unpack_req(input logic [REQ_W-1:0] word);
        req_t r;
        r.src_id = word[REQ_SRC_HI:REQ_SRC_LO];
        r.dst_id = word[REQ_DST_HI:REQ_DST_LO];
        r.rsvd   = word[REQ_RSVD_BIT];
        r.node   = word[REQ_NODE_HI:REQ_NODE_LO];
        return r;
    endfunction

endpackage

// File: rtl/rank_responder.sv
// Pops rank requests addressed to this PE, reads the local rank RAM and pushes a response.
// Define RESP_STATS_EN to add saturating served/dropped counters.
//
// state  | meaning
// IDLE   | waiting for a request and a guaranteed response slot; pops when both present
// FETCH  | request word valid; drop if misrouted, else present node to the rank RAM
// LOOKUP | rank RAM data valid; capture the response word
// SEND   | push the response, holding while the response FIFO is full
module rank_responder
    import rank_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [ID_W-1:0]   id,
    input  logic              empty_req,
    input  logic [REQ_W-1:0]  dataOut_req,
    output logic              read_req,
    output logic [NODE_W-1:0] mem_addr,
    input  logic [RANK_W-1:0] mem_rdata,
    input  logic              full_resp,
    input  logic              almost_full_resp,
    output logic [RESP_W-1:0] dataIn_resp,
    output logic              write_resp,
    output logic              busy
`ifdef RESP_STATS_EN
    ,
    output logic [15:0]       served_cnt,
    output logic [15:0]       dropped_cnt
`endif
);

    state_t            state;
    req_t              req_in;
    logic              hit;
    logic [ID_W-1:0]   src_q;
    logic [NODE_W-1:0] addr_q;
    resp_t             resp_q;
    logic              unused_rsvd;

    assign req_in      = unpack_req(dataOut_req);
    assign unused_rsvd = req_in.rsvd;
    assign hit         = (state == FETCH) && (req_in.dst_id == id);

    // The pop and RAM address are issued in the same cycle the decision is made so that
    // FIFO data lands in FETCH and RAM data lands in LOOKUP (3-cycle pop-to-push latency).
    assign read_req    = reset && (state == IDLE) && !empty_req && !almost_full_resp;
    assign mem_addr    = hit ? req_in.node : addr_q;
    assign write_resp  = (state == SEND) && !full_resp;
    assign dataIn_resp = resp_q;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            src_q  <= '0;
            addr_q <= '0;
            resp_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (read_req) state <= FETCH;
                end
                FETCH: begin
                    if (hit) begin
                        src_q  <= req_in.src_id;
                        addr_q <= req_in.node;
                        state  <= LOOKUP;
                    end else begin
                        state <= IDLE;
                    end
                end
                LOOKUP: begin
                    resp_q.src_id <= src_q;
                    resp_q.node   <= addr_q;
                    resp_q.rank   <= mem_rdata;
                    state         <= SEND;
                end
                SEND: begin
                    if (!full_resp) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RESP_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            served_cnt  <= '0;
            dropped_cnt <= '0;
        end else begin
            if (write_resp && served_cnt != 16'hFFFF) served_cnt <= served_cnt + 16'd1;
            if (state == FETCH && !hit && dropped_cnt != 16'hFFFF)
                dropped_cnt <= dropped_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/rank_responder.md
Name: rank_responder

Overview:
- Serves the other end of the requester's 12-bit request FIFO.
- Pops request words addressed to this processing element (PE) and reads the requested node's rank from the local rank RAM.
- Pushes a response word (destination PE, node index, rank) into the response FIFO back toward the requesting PE.
- One instance per PE; up to 4 PEs, selected by `id`.

Parameters:
- ID_W, 2, PE id width.
- NODE_W, 7, node index width; addresses the local rank RAM.
- RANK_W, 16, rank value width.
- RESP_W, ID_W+NODE_W+RANK_W (25), response word width; derived, not overridable.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- id  in  ID_W  this PE's id; static after reset.
- empty_req  in  1  request FIFO empty.
- dataOut_req  in  12  request FIFO read data; valid the cycle after read_req.
- read_req  out  1  request FIFO pop strobe, 1-cycle pulse.
- mem_addr  out  NODE_W  rank RAM read address.
- mem_rdata  in  RANK_W  rank RAM data; 1-cycle synchronous read latency.
- full_resp  in  1  response FIFO full.
- almost_full_resp  in  1  response FIFO has at most 1 free slot.
- dataIn_resp  out  RESP_W  response word {src_id, node, rank}.
- write_resp  out  1  response FIFO push strobe, 1-cycle pulse.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Request word layout:
  - [11:10] src_id.
  - [9:8] dst_id.
  - [7] reserved, 0.
  - [6:0] node.
- Reset (reset=0, async):
  - FSM goes to IDLE.
  - read_req, write_resp and busy = 0.
  - mem_addr and dataIn_resp = 0.
  - Internal latches = 0.
  - In-flight request is discarded and never re-issued.
- FSM states and transitions:
  - IDLE: if !empty_req && !almost_full_resp, assert read_req for one cycle and go to FETCH. Otherwise stay.
  - FETCH: latch dataOut_req.
    - If dst_id != id, drop the word and return to IDLE.
    - Otherwise drive mem_addr = node and go to LOOKUP.
  - LOOKUP: latch mem_rdata and go to SEND.
  - SEND: if !full_resp, assert write_resp with dataIn_resp = {src_id, node, rank} and return to IDLE. Otherwise hold, with dataIn_resp stable.
- Timing:
  - Latency from read_req to write_resp is 3 cycles when the response FIFO is not full.
  - Peak throughput is 1 response per 4 cycles.
- Gating on almost_full_resp in IDLE guarantees a response slot for the single outstanding request, so SEND stall is only a safety path.
- empty_req is sampled only in IDLE. read_req is never asserted while empty_req=1.
- Simultaneous !empty_req and almost_full_resp: no pop.
- Boundary values:
  - node = 0 and node = 127 are valid addresses; no wrap handling is needed.
  - src_id == id (a self-request) is served normally.
- mem_addr holds its last value outside FETCH/LOOKUP. mem_rdata is ignored outside LOOKUP.

Optional Feature:
- Macro: RESP_STATS_EN.
- Defined: adds outputs served_cnt[15:0] and dropped_cnt[15:0].
  - served_cnt increments on each write_resp.
  - dropped_cnt increments on each misrouted drop.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package rank_pkg holds:
  - ID_W, NODE_W, RANK_W, REQ_W=12.
  - Request field bit positions.
  - Request struct typedef {src_id, dst_id, rsvd, node}.
  - Response struct typedef.
  - FSM state enum {IDLE, FETCH, LOOKUP, SEND}.
- Shared so the requester and rank_responder agree on the word format.
- No sub-module; the statistics counters are inline under the macro.

Test Plan:
- id=2, request 12'b00_10_0_0010100 (src 0, node 20), mem[20]=16'h1234, FIFOs otherwise idle → read_req at T, write_resp at T+3, dataIn_resp={2'd0,7'd20,16'h1234}.
- id=2, request with dst_id=1 → read_req pulse, no write_resp, back in IDLE 2 cycles later; dropped_cnt=1 with RESP_STATS_EN.
- almost_full_resp=1, empty_req=0 → read_req stays 0 indefinitely. Deassert → pop on the next cycle.
- full_resp=1 asserted during LOOKUP → SEND holds with dataIn_resp stable for 5 cycles. Release → exactly one write_resp.
- Back-to-back requests node=0 then node=127 (mem=16'h0001, 16'hFFFF) → two responses 4 cycles apart, correct ranks.
- reset pulled low in LOOKUP → outputs 0 immediately. After release: IDLE, busy=0, no response for the aborted request.
